// File: rtl/qs_pkg.sv
// Shared types and helpers for the quicksort engine.
// Packed-array element access lives here so all users slice the same way.
package qs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    PART,
    PUSH,
    DONE
  } state_t;

  localparam int MAX_BITS = 256;
  typedef logic [MAX_BITS-1:0] flat_t;

  function automatic int idx_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [31:0] elem_get(
    input flat_t a,
    input int    k,
    input int    w
  );
    flat_t m;
    m = (flat_t'(1) << w) - flat_t'(1);
    return 32'((a >> (k * w)) & m);
  endfunction

  function automatic flat_t elem_set(
    input flat_t       a,
    input int          k,
    input int          w,
    input logic [31:0] v
  );
    flat_t m;
    m = ((flat_t'(1) << w) - flat_t'(1)) << (k * w);
    return (a & ~m) | ((flat_t'(v) << (k * w)) & m);
  endfunction

endpackage

// File: rtl/qs_range_stack.sv
// LIFO of pending (lo,hi) sort ranges.
// push0 lands first, push1 on top of it, so push1 pops first.
module qs_range_stack #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push0,
  input  logic [IDX_W-1:0] push0_lo,
  input  logic [IDX_W-1:0] push0_hi,
  input  logic             push1,
  input  logic [IDX_W-1:0] push1_lo,
  input  logic [IDX_W-1:0] push1_hi,
  input  logic             pop,
  output logic [IDX_W-1:0] top_lo,
  output logic [IDX_W-1:0] top_hi,
  output logic             empty,
  output logic             overflow
);

  localparam int SP_W = IDX_W + 2;
  typedef logic [SP_W-1:0] sp_t;

  sp_t              sp;
  sp_t              wr1;
  sp_t              need;
  sp_t              top_idx;
  logic [IDX_W-1:0] lo_mem [DEPTH];
  logic [IDX_W-1:0] hi_mem [DEPTH];

  // Slot addresses and fill level after this cycle's pushes.
  always_comb begin
    wr1     = sp + sp_t'(push0);
    need    = wr1 + sp_t'(push1);
    top_idx = sp - sp_t'(1);
  end

  assign empty    = (sp == '0);
  assign overflow = (need > sp_t'(DEPTH));
  assign top_lo   = lo_mem[top_idx[IDX_W-1:0]];
  assign top_hi   = hi_mem[top_idx[IDX_W-1:0]];

  // Stack pointer: pop and push never coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp <= '0;
    end else if (pop && !empty) begin
      sp <= top_idx;
    end else begin
      sp <= need;
    end
  end

  // Entry storage, guarded against writes past the last slot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push0 && sp < sp_t'(DEPTH)) begin
        lo_mem[sp[IDX_W-1:0]] <= push0_lo;
        hi_mem[sp[IDX_W-1:0]] <= push0_hi;
      end
      if (push1 && wr1 < sp_t'(DEPTH)) begin
        lo_mem[wr1[IDX_W-1:0]] <= push1_lo;
        hi_mem[wr1[IDX_W-1:0]] <= push1_hi;
      end
    end
  end

endmodule

// File: rtl/quicksort_engine.sv
// Iterative in-place Lomuto quicksort over a packed array.
// One compare per cycle; pending sub-ranges live in qs_range_stack.
module quicksort_engine
  import qs_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DEPTH*DATA_W-1:0] array_in,
  input  logic [IDX_W-1:0]        lo_ind,
  input  logic [IDX_W-1:0]        hi_ind,
  input  logic                    descending,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DEPTH*DATA_W-1:0] sorted_array,
  output logic                    busy
);

  localparam int ARR_W = DEPTH * DATA_W;
  typedef logic [ARR_W-1:0]  arr_t;
  typedef logic [DATA_W-1:0] elem_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [IDX_W:0]    idx_x_t;
  localparam idx_x_t HI_MAX = idx_x_t'(DEPTH - 1);

  state_t state;
  idx_t   lo_r;
  idx_t   hi_r;
  idx_t   i_r;
  idx_t   j_r;
  elem_t  pivot;
  logic   desc_r;

  logic   push0;
  logic   push1;
  logic   pop;
  idx_t   push0_lo;
  idx_t   push0_hi;
  idx_t   push1_lo;
  idx_t   push1_hi;
  idx_t   top_lo;
  idx_t   top_hi;
  logic   st_empty;
  logic   st_ovf;

  flat_t  cur;
  elem_t  a_i;
  elem_t  a_j;
  elem_t  a_top;
  arr_t   swapped;
  logic   take;
  idx_t   hi_clamped;
  logic   accept;
  logic   right_ok;
  logic   left_ok;

  assign accept = in_valid && in_ready && (state == IDLE);

  // Partition datapath: operand reads, i/j swap, compare, range math.
  always_comb begin
    cur     = flat_t'(sorted_array);
    a_i     = elem_t'(elem_get(cur, int'(i_r), DATA_W));
    a_j     = elem_t'(elem_get(cur, int'(j_r), DATA_W));
    a_top   = elem_t'(elem_get(cur, int'(top_hi), DATA_W));
    swapped = arr_t'(elem_set(
                elem_set(cur, int'(j_r), DATA_W, 32'(a_i)),
                int'(i_r), DATA_W, 32'(a_j)));
    take    = desc_r ? (a_j >= pivot) : (a_j <= pivot);
    hi_clamped = ({1'b0, hi_ind} > HI_MAX) ?
                 HI_MAX[IDX_W-1:0] : hi_ind;
    right_ok = (idx_x_t'(i_r) + idx_x_t'(1)) < idx_x_t'(hi_r);
    left_ok  = idx_x_t'(i_r) > (idx_x_t'(lo_r) + idx_x_t'(1));
  end

  // Stack requests; the left range goes on top so it pops first.
  always_comb begin
    push0    = 1'b0;
    push1    = 1'b0;
    pop      = 1'b0;
    push0_lo = lo_ind;
    push0_hi = hi_clamped;
    push1_lo = lo_r;
    push1_hi = i_r - idx_t'(1);
    unique case (state)
      IDLE: push0 = accept;
      POP:  pop = !st_empty;
      PUSH: begin
        push0_lo = i_r + idx_t'(1);
        push0_hi = hi_r;
        push0    = right_ok;
        push1    = left_ok;
      end
      default: ;
    endcase
  end

  qs_range_stack #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_stack (
    .clock    (clock),
    .reset    (reset),
    .push0    (push0),
    .push0_lo (push0_lo),
    .push0_hi (push0_hi),
    .push1    (push1),
    .push1_lo (push1_lo),
    .push1_hi (push1_hi),
    .pop      (pop),
    .top_lo   (top_lo),
    .top_hi   (top_hi),
    .empty    (st_empty),
    .overflow (st_ovf)
  );

  // Job sequencing and the working array with registered handshakes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      sorted_array <= '0;
      lo_r         <= '0;
      hi_r         <= '0;
      i_r          <= '0;
      j_r          <= '0;
      pivot        <= '0;
      desc_r       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sorted_array <= array_in;
            desc_r       <= descending;
            in_ready     <= 1'b0;
            busy         <= 1'b1;
            state        <= POP;
          end else begin
            in_ready <= 1'b1;
          end
        end
        POP: begin
          if (st_empty) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (top_lo < top_hi) begin
            lo_r  <= top_lo;
            hi_r  <= top_hi;
            i_r   <= top_lo;
            j_r   <= top_lo;
            pivot <= a_top;
            state <= PART;
          end
        end
        PART: begin
          if (j_r < hi_r) begin
            if (take) begin
              sorted_array <= swapped;
              i_r          <= i_r + idx_t'(1);
            end
            j_r <= j_r + idx_t'(1);
          end else begin
            sorted_array <= swapped;
            state        <= PUSH;
          end
        end
        PUSH: state <= POP;
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The range stack is sized so it can never overflow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!st_ovf);
    end
  end

endmodule

// File: tb/tb_quicksort_engine.sv
// Bench for quicksort_engine: directed vectors plus random jobs
// checked against a queue-sort reference model.
module tb_quicksort_engine;

  localparam int DW = 4;
  localparam int D  = 8;
  localparam int IW = 3;
  typedef logic [D*DW-1:0] arr_t;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  arr_t          array_in;
  logic [IW-1:0] lo_ind;
  logic [IW-1:0] hi_ind;
  logic          descending;
  logic          out_valid;
  logic          out_ready;
  arr_t          sorted_array;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  quicksort_engine #(
    .DATA_W (DW),
    .DEPTH  (D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .array_in     (array_in),
    .lo_ind       (lo_ind),
    .hi_ind       (hi_ind),
    .descending   (descending),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sorted_array (sorted_array),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int clamp_hi(input int hi);
    return (hi > D - 1) ? D - 1 : hi;
  endfunction

  // Reference: pull out the sub-range, sort it, put it back.
  function automatic arr_t ref_sort(input arr_t a, input int lo,
                                    input int hi, input bit desc);
    logic [DW-1:0] q[$];
    arr_t r;
    int h;
    r = a;
    h = clamp_hi(hi);
    for (int k = lo; k <= h; k++) q.push_back(r[k*DW +: DW]);
    if (desc) q.rsort();
    else q.sort();
    for (int k = lo; k <= h; k++) r[k*DW +: DW] = q[k-lo];
    return r;
  endfunction

  task automatic start_job(input arr_t a, input int lo,
                           input int hi, input bit desc);
    int guard;
    logic [31:0] lo_v;
    logic [31:0] hi_v;
    guard = 0;
    lo_v  = lo;
    hi_v  = hi;
    @(negedge clock);
    while (!in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    array_in   = a;
    lo_ind     = lo_v[IW-1:0];
    hi_ind     = hi_v[IW-1:0];
    descending = desc;
    in_valid   = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    array_in = arr_t'($urandom());
  endtask

  // Counts edges from the accept edge until out_valid is seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    @(negedge clock);
    while (!out_valid && cyc < 300) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    check("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    check("out_valid_drop", 64'(out_valid), 64'd0);
    check("in_ready_rise", 64'(in_ready), 64'd1);
  endtask

  task automatic run(input string tag, input arr_t a, input int lo,
                     input int hi, input bit desc,
                     output arr_t res, output int cyc);
    int n;
    int h;
    start_job(a, lo, hi, desc);
    wait_done(cyc);
    res = sorted_array;
    check(tag, 64'(res), 64'(ref_sort(a, lo, hi, desc)));
    h = clamp_hi(hi);
    if (lo < h) begin
      n = h - lo + 1;
      check({tag, "_lat"}, 64'(cyc <= n*(n+5)/2 + 3), 64'd1);
    end else begin
      check({tag, "_lat3"}, 64'(cyc), 64'd3);
    end
    finish_job();
  endtask

  initial begin
    arr_t res;
    arr_t snap;
    int   cyc;
    int   lo;
    int   hi;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    array_in   = '0;
    lo_ind     = '0;
    hi_ind     = '0;
    descending = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_array", 64'(sorted_array), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    run("rev_asc", 32'h0123_4567, 0, 7, 1'b0, res, cyc);
    check("rev_asc_const", 64'(res), 64'h7654_3210);
    check("rev_asc_63", 64'(cyc <= 63), 64'd1);

    run("sorted_asc", 32'h7654_3210, 0, 7, 1'b0, res, cyc);
    check("sorted_lat55", 64'(cyc <= 55), 64'd1);

    run("rev_desc", 32'h0123_4567, 0, 7, 1'b1, res, cyc);
    check("rev_desc_const", 64'(res), 64'h0123_4567);

    run("dups", 32'h3200_3133, 0, 7, 1'b0, res, cyc);
    check("dups_const", 64'(res), 64'h3333_2100);

    run("subrange", 32'h2345_6789, 2, 5, 1'b0, res, cyc);
    check("subrange_const", 64'(res), 64'h2376_5489);

    run("lo_gt_hi", 32'h1357_9bdf, 5, 3, 1'b0, res, cyc);
    check("lo_gt_hi_same", 64'(res), 64'h1357_9bdf);

    run("hi_clamp", 32'h9182_7364, 1, 15, 1'b1, res, cyc);

    // Consumer stalls; outputs must hold and new requests be ignored.
    start_job(32'h5a3c_e172, 0, 7, 1'b0);
    wait_done(cyc);
    snap = sorted_array;
    check("stall_result", 64'(snap),
          64'(ref_sort(32'h5a3c_e172, 0, 7, 1'b0)));
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      array_in = arr_t'($urandom());
      @(posedge clock);
      @(negedge clock);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_array", 64'(sorted_array), 64'(snap));
    end
    in_valid = 1'b0;
    finish_job();

    // Reset while partitioning aborts the job.
    start_job(32'h0123_4567, 0, 7, 1'b0);
    @(negedge clock);
    check("busy_in_job", 64'(busy), 64'd1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_array", 64'(sorted_array), 64'd0);
    reset = 1'b0;
    run("after_abort", 32'hc4e2_81f0, 0, 7, 1'b0, res, cyc);

    for (int k = 0; k < 40; k++) begin
      lo = $urandom_range(0, D - 1);
      hi = $urandom_range(0, D - 1);
      if (k % 3 != 0 && lo > hi) begin
        int t;
        t  = lo;
        lo = hi;
        hi = t;
      end
      run($sformatf("rand%0d", k), arr_t'($urandom()), lo, hi,
          1'($urandom_range(0, 1)), res, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
